// File: rtl/pupif_ctrl.sv
// pupif_ctrl: host-side access controller for the register-macro bus.
// Turns one host request (req/rnw/addr/wdat) into one upen/uprs/upws bus
// transaction and returns rdy/rdat/err to the host. A one-cycle RECOVER
// state swallows the stale ack that the registered slaves return after
// the strobe drops.
// Optional build macro: PUPIF_TIMEOUT_EN -- when defined, an access that
// sees no upack for TO_CYC cycles completes with host_err=1; when
// undefined, ACCESS waits for upack indefinitely and host_err is 0.
module pupif_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int TO_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic              host_rnw,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdat,
   output logic              host_busy,
   output logic              host_rdy,
   output logic [DATA_W-1:0] host_rdat,
   output logic              host_err,
   output logic              upen,
   output logic              uprs,
   output logic              upws,
   output logic [ADDR_W-1:0] upa,
   output logic [DATA_W-1:0] updi,
   input  logic [DATA_W-1:0] updo,
   input  logic              upack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                upen_q, upen_d;
   logic                uprs_q, uprs_d;
   logic                upws_q, upws_d;
   logic [ADDR_W-1:0]   upa_q, upa_d;
   logic [DATA_W-1:0]   updi_q, updi_d;
   logic                rdy_q, rdy_d;
   logic [DATA_W-1:0]   rdat_q, rdat_d;
   logic                busy_q, busy_d;

`ifdef PUPIF_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYC + 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                timeout_hit;

   // Last allowed cycle of the access window; an ack arriving in the same
   // cycle still takes priority in the decode below.
   assign timeout_hit = (cnt_q == CNT_W'(TO_CYC - 1));

   // Wait counter: cleared while idle, counts ACCESS cycles, saturates.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == ACCESS && cnt_q != CNT_W'(TO_CYC)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and error flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign host_err = err_q;
`else
   assign host_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (host_req) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (upack) begin
               state_d = RECOVER;
            end
`ifdef PUPIF_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = RECOVER;
            end
`endif
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: bus strobes, captured address/data, host completion.
   always_comb begin
      upen_d = upen_q;
      uprs_d = uprs_q;
      upws_d = upws_q;
      upa_d  = upa_q;
      updi_d = updi_q;
      rdat_d = rdat_q;
      rdy_d  = 1'b0;
`ifdef PUPIF_TIMEOUT_EN
      err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (host_req) begin
               upen_d = 1'b1;
               uprs_d = host_rnw;
               upws_d = ~host_rnw;
               upa_d  = host_addr;
               updi_d = host_wdat;
            end
         end
         ACCESS: begin
            if (upack) begin
               upen_d = 1'b0;
               uprs_d = 1'b0;
               upws_d = 1'b0;
               rdy_d  = 1'b1;
               if (uprs_q) begin
                  rdat_d = updo;
               end
            end
`ifdef PUPIF_TIMEOUT_EN
            else if (timeout_hit) begin
               upen_d = 1'b0;
               uprs_d = 1'b0;
               upws_d = 1'b0;
               rdy_d  = 1'b1;
               err_d  = 1'b1;
               if (uprs_q) begin
                  rdat_d = '1;
               end
            end
`endif
         end
         default: begin
            upen_d = 1'b0;
            uprs_d = 1'b0;
            upws_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Output registers; every host and bus output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         upen_q <= 1'b0;
         uprs_q <= 1'b0;
         upws_q <= 1'b0;
         upa_q  <= '0;
         updi_q <= '0;
         rdat_q <= '0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         upen_q <= upen_d;
         uprs_q <= uprs_d;
         upws_q <= upws_d;
         upa_q  <= upa_d;
         updi_q <= updi_d;
         rdat_q <= rdat_d;
         rdy_q  <= rdy_d;
         busy_q <= busy_d;
      end
   end

   assign upen      = upen_q;
   assign uprs      = uprs_q;
   assign upws      = upws_q;
   assign upa       = upa_q;
   assign updi      = updi_q;
   assign host_rdat = rdat_q;
   assign host_rdy  = rdy_q;
   assign host_busy = busy_q;

endmodule

// File: tb/tb_pupif_ctrl.sv
// tb_pupif_ctrl: directed bench for pupif_ctrl with a registered-ack
// slave model (ack = strobe delayed one cycle, so it lingers one cycle
// after the strobe drops, just like the register macros).
module tb_pupif_ctrl;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int TO_CYC = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              host_req = 1'b0;
   logic              host_rnw = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdat = '0;
   logic              host_busy;
   logic              host_rdy;
   logic [DATA_W-1:0] host_rdat;
   logic              host_err;
   logic              upen, uprs, upws;
   logic [ADDR_W-1:0] upa;
   logic [DATA_W-1:0] updi;
   logic [DATA_W-1:0] updo;
   logic              upack;

   pupif_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr),
      .host_wdat(host_wdat), .host_busy(host_busy), .host_rdy(host_rdy),
      .host_rdat(host_rdat), .host_err(host_err),
      .upen(upen), .uprs(uprs), .upws(upws), .upa(upa), .updi(updi),
      .updo(updo), .upack(upack)
   );

   always #5 clk = ~clk;

   // Slave model: registered ack, optionally disabled or forced.
   logic              ack_q = 1'b0;
   logic              ack_auto = 1'b1;
   logic              ack_force = 1'b0;
   logic [DATA_W-1:0] slave_val = '0;
   always @(posedge clk) ack_q <= upen;
   assign upack = (ack_auto & ack_q) | ack_force;
   assign updo  = slave_val;

   // Completion pulse counter, sampled mid-cycle.
   int rdy_seen = 0;
   always @(negedge clk) if (host_rdy) rdy_seen++;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access against the auto-ack slave, checked cycle by cycle.
   task automatic do_access(input string tag, input logic rnw, input logic [7:0] addr,
                            input logic [7:0] wdat, input logic [7:0] sval,
                            input logic [7:0] exp_rdat);
      int r0;
      r0 = rdy_seen;
      slave_val = sval;
      host_rnw  = rnw;
      host_addr = addr;
      host_wdat = wdat;
      host_req  = 1'b1;
      tick();                       // cycle N+1
      host_req = 1'b0;
      check({tag, "_upen1"}, upen, 1);
      check({tag, "_uprs"}, uprs, rnw);
      check({tag, "_upws"}, upws, !rnw);
      check({tag, "_upa"}, upa, addr);
      check({tag, "_updi"}, updi, wdat);
      check({tag, "_busy1"}, host_busy, 1);
      check({tag, "_rdy_early"}, host_rdy, 0);
      tick();                       // cycle N+2
      check({tag, "_upen2"}, upen, 1);
      check({tag, "_rdy_n2"}, host_rdy, 0);
      tick();                       // cycle N+3
      check({tag, "_rdy"}, host_rdy, 1);
      check({tag, "_err"}, host_err, 0);
      check({tag, "_upen_off"}, {upen, uprs, upws}, 0);
      check({tag, "_rdat"}, host_rdat, exp_rdat);
      check({tag, "_upa_hold"}, upa, addr);
      check({tag, "_updi_hold"}, updi, wdat);
      tick();                       // cycle N+4
      check({tag, "_rdy_n4"}, host_rdy, 0);
      tick();                       // cycle N+5
      check({tag, "_idle"}, host_busy, 0);
      check({tag, "_one_rdy"}, rdy_seen - r0, 1);
   endtask

   typedef struct {
      string      tag;
      logic       rnw;
      logic [7:0] addr;
      logic [7:0] wdat;
      logic [7:0] sval;
      logic [7:0] exp_rdat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int r0;
      int got_k;
      logic seen_rdy;

      vecs[0] = '{"rd_a5",   1'b1, 8'h05, 8'h00, 8'hA5, 8'hA5};
      vecs[1] = '{"wr_3c",   1'b0, 8'h12, 8'h3C, 8'h77, 8'hA5};
      vecs[2] = '{"rd_00",   1'b1, 8'hFF, 8'h9A, 8'h00, 8'h00};
      vecs[3] = '{"rd_ff",   1'b1, 8'h80, 8'h00, 8'hFF, 8'hFF};
      vecs[4] = '{"wr_ff",   1'b0, 8'h00, 8'hFF, 8'h5A, 8'hFF};
      vecs[5] = '{"wr_00",   1'b0, 8'hAB, 8'h00, 8'hC3, 8'hFF};
      vecs[6] = '{"rd_3c",   1'b1, 8'h01, 8'h00, 8'h3C, 8'h3C};

      // Reset state
      repeat (3) tick();
      check("rst_bus", {upen, uprs, upws, upa, updi}, 0);
      check("rst_host", {host_busy, host_rdy, host_err, host_rdat}, 0);
      rst_n = 1'b1;
      tick();
      check("idle_no_req", host_busy, 0);

      // Table-driven accesses
      for (int i = 0; i < 7; i++) begin
         do_access(vecs[i].tag, vecs[i].rnw, vecs[i].addr, vecs[i].wdat,
                   vecs[i].sval, vecs[i].exp_rdat);
      end

      // host_req during RECOVER is ignored, not queued
      slave_val = 8'h44; host_rnw = 1'b1; host_addr = 8'h20; host_req = 1'b1;
      tick(); host_req = 1'b0;
      tick();
      tick();
      check("rec_rdy", host_rdy, 1);
      check("rec_rdat", host_rdat, 8'h44);
      host_req = 1'b1; host_addr = 8'h21;
      tick(); host_req = 1'b0;
      check("rec_ign_upen", upen, 0);
      check("rec_ign_busy", host_busy, 0);
      tick();
      check("rec_ign_upen2", upen, 0);

      // Stale ack then immediate second read
      r0 = rdy_seen;
      slave_val = 8'h11; host_rnw = 1'b1; host_addr = 8'h30; host_req = 1'b1;
      tick(); host_req = 1'b0;
      tick();
      tick();                       // N+3: RECOVER, stale ack present
      check("b2b_rdy1", host_rdy, 1);
      check("b2b_rdat1", host_rdat, 8'h11);
      slave_val = 8'h22;
      tick();                       // N+4: IDLE
      host_addr = 8'h31; host_req = 1'b1;
      tick(); host_req = 1'b0;
      check("b2b_uprs2", uprs, 1);
      check("b2b_upa2", upa, 8'h31);
      tick();
      tick();
      check("b2b_rdy2", host_rdy, 1);
      check("b2b_rdat2", host_rdat, 8'h22);
      check("b2b_err2", host_err, 0);
      tick();
      tick();
      check("b2b_count", rdy_seen - r0, 2);

      // Ack arrives on the last counted cycle: ack wins
      ack_auto = 1'b0;
      slave_val = 8'h96; host_rnw = 1'b1; host_addr = 8'h40; host_req = 1'b1;
      tick(); host_req = 1'b0;      // N+1
      seen_rdy = 1'b0;
      for (int k = 1; k < 16; k++) begin
         if (host_rdy) seen_rdy = 1'b1;
         tick();
      end
      check("tack_no_early_rdy", seen_rdy, 0);
      ack_force = 1'b1;             // cycle N+16
      tick();
      ack_force = 1'b0;
      check("tack_rdy", host_rdy, 1);
      check("tack_err", host_err, 0);
      check("tack_rdat", host_rdat, 8'h96);
      ack_auto = 1'b1;
      tick();
      tick();
      check("tack_idle", host_busy, 0);

      // Reset pulse mid-access discards the transaction
      r0 = rdy_seen;
      slave_val = 8'h5E; host_rnw = 1'b1; host_addr = 8'h50; host_req = 1'b1;
      tick(); host_req = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rstm_strobes", {upen, uprs, upws}, 0);
      check("rstm_busy", host_busy, 0);
      check("rstm_rdy", host_rdy, 0);
      tick();
      tick();
      check("rstm_no_rdy", rdy_seen - r0, 0);
      check("rstm_still_idle", {host_busy, upen}, 0);
      do_access("rstm_next", 1'b1, 8'h51, 8'h00, 8'h5E, 8'h5E);

      // No ack at all
      ack_auto = 1'b0;
`ifdef PUPIF_TIMEOUT_EN
      // Timed-out write leaves host_rdat alone
      host_rnw = 1'b0; host_addr = 8'h61; host_wdat = 8'h01; host_req = 1'b1;
      tick(); host_req = 1'b0;
      got_k = 0;
      for (int k = 1; k <= 40 && got_k == 0; k++) begin
         if (host_rdy) got_k = k;
         else tick();
      end
      check("to_wr_cycle", got_k, 17);
      check("to_wr_err", host_err, 1);
      check("to_wr_rdat", host_rdat, 8'h5E);
      tick(); tick();
      check("to_wr_idle", host_busy, 0);
      // Timed-out read returns all-ones
      slave_val = 8'h12; host_rnw = 1'b1; host_addr = 8'h60; host_req = 1'b1;
      tick(); host_req = 1'b0;
      got_k = 0;
      for (int k = 1; k <= 40 && got_k == 0; k++) begin
         if (host_rdy) got_k = k;
         else tick();
      end
      check("to_rd_cycle", got_k, 17);
      check("to_rd_err", host_err, 1);
      check("to_rd_rdat", host_rdat, 8'hFF);
      check("to_rd_strobes", {upen, uprs, upws}, 0);
      tick(); tick();
      check("to_rd_idle", host_busy, 0);
`else
      r0 = rdy_seen;
      got_k = 0;
      slave_val = 8'h12; host_rnw = 1'b1; host_addr = 8'h60; host_req = 1'b1;
      tick(); host_req = 1'b0;
      repeat (1000) tick();
      check("nto_no_rdy", rdy_seen - r0, 0);
      check("nto_busy", host_busy, 1);
      check("nto_strobe", {upen, uprs}, 2'b11);
      check("nto_err", host_err, got_k);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("nto_rst_idle", host_busy, 0);
`endif
      ack_auto = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
